layer_output_serializer: RTL and testbench
==========================================

Name: layer_output_serializer

Overview:
- Downstream stage of a layer of neurons. Captures the parallel outputs of all `numNeurons` neurons in one cycle.
- Replays them as a serial stream, one value per clock, suitable for driving the next layer's `myinput`/`myinputValid` pair.
- Double-buffered: one result vector can be accepted while the previous one is still being streamed. Overflow beyond that is flagged, not stalled.

Parameters:
- numNeurons, 10, neurons in the producing layer (≥2)
- dataWidth, 16, width of each neuron output (signed fixed-point)
- idxWidth, $clog2(numNeurons) (localparam), width of the index outputs

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- in_data  in  numNeurons*dataWidth  neuron outputs packed; neuron k at bits [k*dataWidth +: dataWidth]
- in_valid  in  numNeurons  per-neuron outvalid; bit 0 qualifies capture
- out_data  out  dataWidth  serialized value
- out_valid  out  1  out_data valid this cycle (feeds next-layer myinputValid)
- out_index  out  idxWidth  neuron index of out_data
- out_last  out  1  high with the element at index numNeurons-1
- busy  out  1  high whenever streaming or pending buffer occupied
- overrun  out  1  sticky; a vector was dropped
- argmax_valid  out  1  see Optional Feature
- argmax_index  out  idxWidth  see Optional Feature
- argmax_value  out  dataWidth  see Optional Feature

Behaviour:
- Reset: all outputs 0, state IDLE, pending_full=0, overrun=0. Reset mid-stream aborts the stream immediately; no further out_valid until a new capture.
- Capture event: rising edge with in_valid[0]=1. Neurons of a layer fire in lock-step, so in_valid[1..] is ignored.
- Storage: an active register and a pending register, each numNeurons*dataWidth wide, plus pending_full.
- IDLE:
  - On capture: active<=in_data, cnt<=0, go to SEND.
  - out_valid goes high the cycle after capture (latency 1).
- SEND, each cycle:
  - out_valid=1, out_data=active[cnt], out_index=cnt, out_last=(cnt==numNeurons-1). Outputs are registered.
  - cnt increments by 1 every cycle; there is no backpressure.
- Capture during SEND, not last element:
  - pending_full=0: pending<=in_data, pending_full<=1.
  - pending_full=1: vector dropped, overrun<=1, existing pending kept.
- Last element (cnt==numNeurons-1), no bubble in any case:
  - pending_full=1: active<=pending, cnt<=0, stay SEND. If a capture occurs the same cycle, pending<=in_data and pending_full stays 1; otherwise pending_full<=0.
  - pending_full=0 with capture: active<=in_data, cnt<=0, stay SEND.
  - pending_full=0, no capture: go IDLE. out_valid is 0 the following cycle.
- Derived outputs:
  - busy = (state==SEND) | pending_full.
  - overrun clears only on rst.
- Data passes through unmodified; no arithmetic on the stream path.

Optional Feature:
- Macro: LAYER_SER_ARGMAX_EN.
- Defined:
  - A running signed max is tracked over each streamed vector.
  - Ties keep the lowest index.
  - The comparator resets at index 0 of every vector.
  - argmax_valid pulses for one cycle, the cycle after out_last. argmax_index and argmax_value hold the result and remain stable until the next pulse.
  - Back-to-back vectors each produce their own pulse.
- Not defined: argmax_valid, argmax_index and argmax_value are tied to 0; no comparator logic is synthesized.

Test Plan:
- Single vector, numNeurons=10, in_data[k]=k+1, in_valid[0] pulsed once at cycle T -> out_valid high T+1..T+10, out_data 1..10, out_index 0..9, out_last only at T+10, busy low at T+11.
- Second capture at T+4 with values 100+k -> stream continues without bubble: T+11..T+20 shows 100..109, overrun=0.
- Captures at T, T+3 and T+5 -> third vector dropped, overrun=1 from T+6 and sticky; exactly 20 valid outputs.
- Capture coincident with out_last, pending empty -> next cycle out_index=0 with the new data, no gap.
- rst asserted at T+5 mid-stream -> out_valid=0 at T+6, busy=0, overrun=0, and no outputs until the next capture.
- With LAYER_SER_ARGMAX_EN, vector {-3,7,2,7,-128,0,1,5,6,-1} -> argmax_valid one cycle after out_last, argmax_index=1, argmax_value=7. Without the macro all three argmax outputs stay 0.

Source files
------------

// File: rtl/layer_output_serializer.sv
// Layer output serializer: captures all neuron outputs of a layer in one cycle and replays
// them one per clock, double-buffered. Define LAYER_SER_ARGMAX_EN to add a running argmax.
module layer_output_serializer #(
  parameter  int numNeurons = 10,
  parameter  int dataWidth  = 16,
  localparam int idxWidth   = $clog2(numNeurons)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [numNeurons*dataWidth-1:0] in_data,
  input  logic [numNeurons-1:0]           in_valid,
  output logic [dataWidth-1:0]            out_data,
  output logic                            out_valid,
  output logic [idxWidth-1:0]             out_index,
  output logic                            out_last,
  output logic                            busy,
  output logic                            overrun,
  output logic                            argmax_valid,
  output logic [idxWidth-1:0]             argmax_index,
  output logic [dataWidth-1:0]            argmax_value
);

  typedef enum logic {IDLE, SEND} state_t;

  typedef logic [numNeurons-1:0][dataWidth-1:0] vec_t;

  localparam logic [idxWidth-1:0] last_idx = idxWidth'(numNeurons - 1);

  state_t               state;
  logic [idxWidth-1:0]  cnt;
  logic [idxWidth-1:0]  cnt_next;
  logic                 pending_full;
  vec_t                 active;
  vec_t                 pending;

  logic capture;
  logic start_from_in;
  logic start_from_pend;
  logic pend_load;
  logic advance;
  logic drop;

  // Neurons of a layer fire in lock-step, so only bit 0 qualifies a capture.
  assign capture = in_valid[0];

  logic unused_valid_bits;
  assign unused_valid_bits = |in_valid[numNeurons-1:1];

  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch can be inferred.
    start_from_in   = 1'b0;
    start_from_pend = 1'b0;
    pend_load       = 1'b0;
    advance         = 1'b0;
    drop            = 1'b0;
    cnt_next        = cnt + idxWidth'(1);
    if (state == SEND) begin
      if (cnt == last_idx) begin
        // Last element: reload from pending (or a coincident capture) with no bubble.
        start_from_pend = pending_full;
        start_from_in   = capture && !pending_full;
        pend_load       = capture && pending_full;
      end else begin
        advance   = 1'b1;
        pend_load = capture && !pending_full;
        drop      = capture && pending_full;
      end
    end else begin
      start_from_in = capture;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
      state        <= IDLE;
      cnt          <= '0;
      pending_full <= 1'b0;
      overrun      <= 1'b0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_index    <= '0;
      out_last     <= 1'b0;
    end else begin
      if (drop) begin
        overrun <= 1'b1;
      end

      if (start_from_pend) begin
        pending_full <= pend_load;
      end else if (pend_load) begin
        pending_full <= 1'b1;
      end

      if (start_from_in || start_from_pend) begin
        state     <= SEND;
        cnt       <= '0;
        out_valid <= 1'b1;
        out_index <= '0;
        out_last  <= 1'b0;
        out_data  <= start_from_pend ? pending[0] : in_data[dataWidth-1:0];
      end else if (advance) begin
        cnt       <= cnt_next;
        out_valid <= 1'b1;
        out_index <= cnt_next;
        out_last  <= (cnt_next == last_idx);
        out_data  <= active[cnt_next];
      end else begin
        state     <= IDLE;
        cnt       <= '0;
        out_valid <= 1'b0;
        out_index <= '0;
        out_last  <= 1'b0;
        out_data  <= '0;
      end
    end
  end

  // NOTE: the vector buffers carry no reset; nothing reads them until a capture has loaded them.
  always_ff @(posedge clk) begin
    if (start_from_in) begin
      active <= in_data;
    end else if (start_from_pend) begin
      active <= pending;
    end
    if (pend_load) begin
      pending <= in_data;
    end
  end

  // pending_full implies SEND, but both terms are kept so busy reads as intended.
  assign busy = (state == SEND) || pending_full;

`ifdef LAYER_SER_ARGMAX_EN
  logic signed [dataWidth-1:0] run_max;
  logic signed [dataWidth-1:0] best_val;
  logic [idxWidth-1:0]         run_idx;
  logic [idxWidth-1:0]         best_idx;

  // Index 0 restarts the comparison; the strict compare keeps the lowest index on ties.
  always_comb begin
    best_val = run_max;
    best_idx = run_idx;
    if ((out_index == '0) || ($signed(out_data) > run_max)) begin
      best_val = $signed(out_data);
      best_idx = out_index;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run_max      <= '0;
      run_idx      <= '0;
      argmax_valid <= 1'b0;
      argmax_index <= '0;
      argmax_value <= '0;
    end else begin
      argmax_valid <= 1'b0;
      if (out_valid) begin
        run_max <= best_val;
        run_idx <= best_idx;
        if (out_last) begin
          argmax_valid <= 1'b1;
          argmax_index <= best_idx;
          argmax_value <= best_val;
        end
      end
    end
  end
`else
  assign argmax_valid = 1'b0;
  assign argmax_index = '0;
  assign argmax_value = '0;
`endif

endmodule

// File: tb/tb_layer_output_serializer.sv
// Self-checking bench for layer_output_serializer: randomized captures against a
// buffer-occupancy reference model, with a scoreboard queue drained by a monitor.
module tb_layer_output_serializer;

  localparam int N  = 10;
  localparam int DW = 16;
  localparam int IW = $clog2(N);

  typedef logic [N-1:0][DW-1:0] vec_t;

  typedef struct {
    logic [DW-1:0] data;
    int            idx;
    bit            last;
  } elem_t;

  typedef struct {
    int            idx;
    logic [DW-1:0] val;
  } am_t;

  logic            clk;
  logic            rst;
  logic [N*DW-1:0] in_data;
  logic [N-1:0]    in_valid;
  logic [DW-1:0]   out_data;
  logic            out_valid;
  logic [IW-1:0]   out_index;
  logic            out_last;
  logic            busy;
  logic            overrun;
  logic            argmax_valid;
  logic [IW-1:0]   argmax_index;
  logic [DW-1:0]   argmax_value;

  layer_output_serializer #(.numNeurons(N), .dataWidth(DW)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_index    (out_index),
    .out_last     (out_last),
    .busy         (busy),
    .overrun      (overrun),
    .argmax_valid (argmax_valid),
    .argmax_index (argmax_index),
    .argmax_value (argmax_value)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    checks   = 0;
  int    failures = 0;
  elem_t sb[$];
  am_t   am_q[$];
  int    pend_cnt    = 0;   // elements still to appear after the one currently shown
  bit    exp_valid   = 0;
  bit    exp_overrun = 0;
  bit    am_due      = 0;
  bit    mon_en      = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t seq_vec(input int base);
    vec_t v;
    for (int k = 0; k < N; k++) v[k] = DW'(base + k);
    return v;
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    for (int k = 0; k < N; k++)
      v[k] = ($urandom_range(0, 1) == 1) ? DW'($urandom) : DW'(int'($urandom_range(0, 6)) - 3);
    return v;
  endfunction

  // Reference model: at most one whole vector may wait beyond the element being shown;
  // anything more is dropped. One element leaves the backlog every clock.
  task automatic step(input bit cap, input bit r, input vec_t v);
    logic [N-2:0] junk;
    int           bi;
    junk     = (N-1)'($urandom);
    in_data  = v;
    in_valid = {junk, cap};
    rst      = r;
    @(posedge clk);
    if (r) begin
      pend_cnt    = 0;
      sb.delete();
      am_q.delete();
      exp_overrun = 0;
      exp_valid   = 0;
      am_due      = 0;
    end else begin
      if (cap) begin
        if (pend_cnt <= N) begin
          bi = 0;
          for (int i = 0; i < N; i++) begin
            sb.push_back('{v[i], i, (i == N - 1)});
            if ($signed(v[i]) > $signed(v[bi])) bi = i;
          end
          am_q.push_back('{bi, v[bi]});
          pend_cnt += N;
        end else begin
          exp_overrun = 1;
        end
      end
      exp_valid = (pend_cnt > 0);
      if (pend_cnt > 0) pend_cnt--;
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, rand_vec());
  endtask

  // Monitor: compares the DUT against the model on the falling edge.
  initial begin
    elem_t e;
    am_t   a;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        check("out_valid", 64'(out_valid), 64'(exp_valid));
        check("busy", 64'(busy), 64'(exp_valid));
        check("overrun", 64'(overrun), 64'(exp_overrun));
`ifdef LAYER_SER_ARGMAX_EN
        check("argmax_valid", 64'(argmax_valid), 64'(am_due));
        if (am_due) begin
          if (am_q.size() == 0) begin
            check("argmax_queue_empty", 64'(1), 64'(0));
          end else begin
            a = am_q.pop_front();
            check("argmax_index", 64'(argmax_index), 64'(a.idx));
            check("argmax_value", 64'(argmax_value), 64'(a.val));
          end
        end
`else
        check("argmax_tied_zero", 64'({argmax_valid, argmax_index, argmax_value}), 64'(0));
`endif
        am_due = 0;
        if (exp_valid) begin
          if (sb.size() == 0) begin
            check("scoreboard_underflow", 64'(1), 64'(0));
          end else begin
            e = sb.pop_front();
            check("out_data", 64'(out_data), 64'(e.data));
            check("out_index", 64'(out_index), 64'(e.idx));
            check("out_last", 64'(out_last), 64'(e.last));
            if (e.last) am_due = 1;
          end
        end
      end
    end
  end

  initial begin
    int   vals[N];
    vec_t am_vec;
    vals = '{-3, 7, 2, 7, -128, 0, 1, 5, 6, -1};
    for (int k = 0; k < N; k++) am_vec[k] = DW'(vals[k]);

    rst      = 1'b1;
    in_valid = '0;
    in_data  = '0;
    step(1'b0, 1'b1, rand_vec());
    mon_en = 1;
    step(1'b0, 1'b1, rand_vec());

    // Single vector.
    step(1'b1, 1'b0, seq_vec(1));
    idle(14);

    // Second capture mid-stream streams back-to-back.
    step(1'b1, 1'b0, seq_vec(1));
    idle(3);
    step(1'b1, 1'b0, seq_vec(100));
    idle(20);

    // Third capture while pending is full is dropped.
    step(1'b1, 1'b0, seq_vec(1));
    idle(2);
    step(1'b1, 1'b0, seq_vec(200));
    idle(1);
    step(1'b1, 1'b0, seq_vec(300));
    idle(25);
    check("overrun_sticky", 64'(overrun), 64'(1));
    step(1'b0, 1'b1, rand_vec());

    // Capture coincident with the last element, pending empty.
    step(1'b1, 1'b0, seq_vec(10));
    idle(9);
    step(1'b1, 1'b0, seq_vec(50));
    idle(14);

    // Reset mid-stream aborts; nothing until the next capture.
    step(1'b1, 1'b0, seq_vec(1));
    idle(4);
    step(1'b0, 1'b1, rand_vec());
    idle(6);

    // Argmax vector with a tie and negatives.
    step(1'b1, 1'b0, am_vec);
    idle(13);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 199) == 0) step(1'b0, 1'b1, rand_vec());
      else step($urandom_range(0, 5) == 0, 1'b0, rand_vec());
    end

    idle(30);
    check("scoreboard_drained", 64'(sb.size()), 64'(0));
`ifdef LAYER_SER_ARGMAX_EN
    check("argmax_drained", 64'(am_q.size()), 64'(0));
`endif
    mon_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
